// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - mode encodings and direction state for the timebase counter
package counter_pkg;

   localparam logic [1:0] MODE_UP     = 2'd0;
   localparam logic [1:0] MODE_DOWN   = 2'd1;
   localparam logic [1:0] MODE_UPDOWN = 2'd2;
   localparam logic [1:0] MODE_RSVD   = 2'd3;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - shadowed prescaler producing the count-advance tick
module counter_prescaler #(
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   clear,
   input  logic                   load_shadow,
   input  logic [PRESC_WIDTH-1:0] prescale,
   output logic                   tick
);

   logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [PRESC_WIDTH-1:0] prescale_sh_q, prescale_sh_d;

   // >= so a ratio lowered below the running pcnt ends the period at once
   assign tick = enable & ~clear & (pcnt_q >= prescale_sh_q);

   always_comb begin
      pcnt_d        = pcnt_q;
      prescale_sh_d = load_shadow ? prescale : prescale_sh_q;
      if (clear) begin
         pcnt_d = '0;
      end else if (enable) begin
         pcnt_d = tick ? '0 : pcnt_q + PRESC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt_q        <= '0;
         prescale_sh_q <= '0;
      end else begin
         pcnt_q        <= pcnt_d;
         prescale_sh_q <= prescale_sh_d;
      end
   end

endmodule

// File: rtl/counter_timebase.sv
// rtl/counter_timebase.sv - prescaled up/down/centre-aligned timebase with shadowed period and mode
module counter_timebase
   import counter_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       period,
   input  logic [PRESC_WIDTH-1:0] prescale,
   output logic [WIDTH-1:0]       count,
   output logic                   dir,
   output logic                   ovf,
   output logic                   unf
);

   logic [WIDTH-1:0] period_sh_q, period_sh_d;
   logic [1:0]       mode_sh_q, mode_sh_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   dir_e             dir_q, dir_d;

   logic             tick;
   logic             update_evt;
   logic             load_shadow;
   logic             at_top;
   logic             at_zero;
   logic             going_up;
   logic [WIDTH-1:0] turn_target;
   logic [WIDTH-1:0] bottom_target;

   assign at_top   = count_q >= period_sh_q;
   assign at_zero  = count_q == '0;
   assign going_up = dir_q == DIR_UP;

   // Turn targets clamp to 0 so a zero period never leaves count 0
   assign turn_target   = (period == '0) ? '0 : period - WIDTH'(1);
   assign bottom_target = (period_sh_q == '0) ? '0 : WIDTH'(1);

   always_comb begin
      unique case (mode_sh_q)
         MODE_DOWN:           update_evt = tick & at_zero;
         MODE_UPDOWN:         update_evt = tick & going_up & at_top;
         MODE_UP, MODE_RSVD:  update_evt = tick & at_top;
      endcase
   end

   assign load_shadow = ~enable | clear | update_evt;

   always_comb begin
      period_sh_d = load_shadow ? period : period_sh_q;
      mode_sh_d   = load_shadow ? mode   : mode_sh_q;
   end

   counter_prescaler #(
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_prescaler (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .clear       (clear),
      .load_shadow (load_shadow),
      .prescale    (prescale),
      .tick        (tick)
   );

   // Direction FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_q <= DIR_UP;
      end else begin
         dir_q <= dir_d;
      end
   end

   // Direction FSM: next state
   always_comb begin
      dir_d = dir_q;
      if (clear) begin
         dir_d = (mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
      end else if (tick) begin
         unique case (mode_sh_q)
            MODE_DOWN: dir_d = DIR_DOWN;
            MODE_UPDOWN: begin
               if (going_up && at_top) begin
                  dir_d = (period == '0) ? DIR_UP : DIR_DOWN;
               end else if (!going_up && at_zero) begin
                  dir_d = DIR_UP;
               end
            end
            MODE_UP, MODE_RSVD: dir_d = DIR_UP;
         endcase
      end
   end

   // Direction FSM: output
   always_comb begin
      dir = (dir_q == DIR_UP);
   end

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (clear) begin
         count_d = (mode == MODE_DOWN) ? period : '0;
      end else if (tick) begin
         unique case (mode_sh_q)
            MODE_DOWN: begin
               if (at_zero) begin
                  count_d = period;
                  unf_d   = 1'b1;
               end else begin
                  count_d = count_q - WIDTH'(1);
               end
            end
            MODE_UPDOWN: begin
               if (going_up && at_top) begin
                  count_d = turn_target;
                  ovf_d   = 1'b1;
               end else if (!going_up && at_zero) begin
                  count_d = bottom_target;
                  unf_d   = 1'b1;
               end else if (going_up) begin
                  count_d = count_q + WIDTH'(1);
               end else begin
                  count_d = count_q - WIDTH'(1);
               end
            end
            MODE_UP, MODE_RSVD: begin
               if (at_top) begin
                  count_d = '0;
                  ovf_d   = 1'b1;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_sh_q <= '1;
         mode_sh_q   <= MODE_UP;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         period_sh_q <= period_sh_d;
         mode_sh_q   <= mode_sh_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_counter_timebase.sv
// tb/tb_counter_timebase.sv - scoreboard bench for counter_timebase
module tb_counter_timebase;
   import counter_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic [1:0]  mode = MODE_UP;
   logic [15:0] period = 16'd4;
   logic [7:0]  prescale = 8'd0;
   logic [15:0] count;
   logic        dir;
   logic        ovf;
   logic        unf;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected flags code: [0] unf, [1] ovf, [2] dir, [3] dir unchecked,
   // [4] drive enable low, [5] drive clear high
   typedef struct {
      int    c;
      int    f;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   cq[$];
   int   fq[$];

   counter_timebase #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .clear    (clear),
      .mode     (mode),
      .period   (period),
      .prescale (prescale),
      .count    (count),
      .dir      (dir),
      .ovf      (ovf),
      .unf      (unf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic run_seq(input string name, input logic rst, input logic [1:0] md,
                          input logic [15:0] per, input logic [7:0] psc);
      exp_t e;
      int   f;
      for (int i = 0; i < cq.size(); i++) begin
         f = fq[i];
         @(negedge clk);
         reset_n  = rst;
         enable   = (f & 16) == 0;
         clear    = (f & 32) != 0;
         mode     = md;
         period   = per;
         prescale = psc;
         sb.push_back('{c: cq[i], f: f, tag: $sformatf("%s[%0d]", name, i)});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check_eq({e.tag, ".count"}, 32'(count), 32'(e.c));
         if ((e.f & 8) != 0)
            check_eq({e.tag, ".ovf_unf"}, {30'd0, ovf, unf}, 32'(e.f & 3));
         else
            check_eq({e.tag, ".dir_ovf_unf"}, {29'd0, dir, ovf, unf}, 32'(e.f & 7));
      end
   endtask

   initial begin
      cq = '{0, 0}; fq = '{4, 4};
      run_seq("reset", 1'b0, MODE_UP, 16'd4, 8'd0);
      cq = '{0}; fq = '{20};
      run_seq("release", 1'b1, MODE_UP, 16'd4, 8'd0);

      cq = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
      fq = '{4, 4, 4, 4, 6, 4, 4, 4, 4, 6, 4, 4};
      run_seq("up_p4", 1'b1, MODE_UP, 16'd4, 8'd0);

      cq = '{0, 1, 2, 3, 4, 5, 6, 7}; fq = '{36, 4, 4, 4, 4, 4, 4, 4};
      run_seq("up_p10", 1'b1, MODE_UP, 16'd10, 8'd0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_eq("async_rst.count", 32'(count), 32'd0);
      check_eq("async_rst.dir_ovf_unf", {29'd0, dir, ovf, unf}, 32'd4);
      cq = '{0}; fq = '{4};
      run_seq("rst_hold", 1'b0, MODE_UP, 16'd10, 8'd0);
      cq = '{1, 2}; fq = '{4, 4};
      run_seq("rst_resume", 1'b1, MODE_UP, 16'd10, 8'd0);

      cq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 0};
      fq = '{36, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 6};
      run_seq("up_psc2", 1'b1, MODE_UP, 16'd4, 8'd2);

      cq = '{3, 2, 1, 0, 3, 2}; fq = '{32, 0, 0, 0, 1, 0};
      run_seq("down_p3", 1'b1, MODE_DOWN, 16'd3, 8'd0);
      cq = '{3, 3, 2, 2, 2, 2, 1, 1, 0, 0, 3, 3};
      fq = '{32, 0, 0, 0, 16, 16, 0, 0, 0, 0, 1, 0};
      run_seq("down_freeze", 1'b1, MODE_DOWN, 16'd3, 8'd1);

      cq = '{0, 1, 2, 3, 2, 1, 0, 1, 2}; fq = '{36, 4, 4, 4, 2, 0, 0, 5, 4};
      run_seq("updown_p3", 1'b1, MODE_UPDOWN, 16'd3, 8'd0);

      cq = '{0, 1}; fq = '{36, 4};
      run_seq("shadow_en_a", 1'b1, MODE_UP, 16'd4, 8'd0);
      cq = '{2, 3, 4, 0, 1, 2, 0}; fq = '{4, 4, 4, 6, 4, 4, 6};
      run_seq("shadow_en_b", 1'b1, MODE_UP, 16'd2, 8'd0);
      cq = '{0, 1, 2, 3, 4}; fq = '{36, 4, 4, 4, 4};
      run_seq("shadow_dis_a", 1'b1, MODE_UP, 16'd4, 8'd0);
      cq = '{4, 0, 1}; fq = '{20, 6, 4};
      run_seq("shadow_dis_b", 1'b1, MODE_UP, 16'd2, 8'd0);

      cq = '{0, 0, 0, 0}; fq = '{36, 6, 6, 6};
      run_seq("up_p0", 1'b1, MODE_UP, 16'd0, 8'd0);
      cq = '{0, 0, 0}; fq = '{32, 1, 1};
      run_seq("down_p0", 1'b1, MODE_DOWN, 16'd0, 8'd0);
      cq = '{0, 0, 0, 0}; fq = '{36, 10, 10, 10};
      run_seq("updown_p0", 1'b1, MODE_UPDOWN, 16'd0, 8'd0);

      cq = '{0, 1, 2, 3, 4, 0, 1, 2}; fq = '{36, 4, 4, 4, 4, 36, 4, 4};
      run_seq("clr_wins", 1'b1, MODE_UP, 16'd4, 8'd0);
      cq = '{0, 1, 2, 0, 1}; fq = '{36, 4, 4, 6, 4};
      run_seq("rsvd_p2", 1'b1, MODE_RSVD, 16'd2, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
